// File: rtl/vga_scanout.sv
// 640x480@60 scan-out engine: walks the 80x60 cell video memory and drives VGA
// colour and sync. It also reports frame start and vertical blank so software can time its writes.
module vga_scanout #(
  parameter int H_DISP     = 640,
  parameter int H_FP       = 16,
  parameter int H_PW       = 96,
  parameter int H_BP       = 48,
  parameter int V_DISP     = 480,
  parameter int V_FP       = 10,
  parameter int V_PW       = 2,
  parameter int V_BP       = 33,
  parameter int CELL_SHIFT = 3
) (
  input  logic        Clock,
  input  logic        Reset,
  output logic [12:0] oReadAddress,
  input  logic [2:0]  iReadData,
  output logic        VGA_RED,
  output logic        VGA_GREEN,
  output logic        VGA_BLUE,
  output logic        VGA_HSYNC,
  output logic        VGA_VSYNC,
  output logic        oFrameStart,
  output logic        oVBlank
);

  localparam int H_TOTAL = H_DISP + H_FP + H_PW + H_BP;
  localparam int V_TOTAL = V_DISP + V_FP + V_PW + V_BP;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_DISP_W   = 10'(H_DISP);
  localparam logic [9:0] V_DISP_W   = 10'(V_DISP);
  localparam logic [9:0] H_SYNC_LO  = 10'(H_DISP + H_FP);
  localparam logic [9:0] H_SYNC_HI  = 10'(H_DISP + H_FP + H_PW - 1);
  localparam logic [9:0] V_SYNC_LO  = 10'(V_DISP + V_FP);
  localparam logic [9:0] V_SYNC_HI  = 10'(V_DISP + V_FP + V_PW - 1);

  logic       pix_en_q, pix_en_d;
  logic [9:0] hcount_q, hcount_d;
  logic [9:0] vcount_q, vcount_d;
  logic [2:0] rgb_q, rgb_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       vblank_q, vblank_d;
  logic       frame_start_q, frame_start_d;

  logic       h_active, v_active, active;
  logic       h_last, v_last;
  logic [6:0] col;
  logic [5:0] row;

  assign h_active = hcount_q < H_DISP_W;
  assign v_active = vcount_q < V_DISP_W;
  assign active   = h_active & v_active;
  assign h_last   = hcount_q == H_LAST;
  assign v_last   = vcount_q == V_LAST;

  // Cell coordinates keep only the upper counter bits; inside the display they never exceed 79/59.
  assign col          = 7'(hcount_q >> CELL_SHIFT);
  assign row          = 6'(vcount_q >> CELL_SHIFT);
  assign oReadAddress = active ? {col, row} : 13'd0;

  // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    pix_en_d = ~pix_en_q;
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    if (pix_en_q) begin
      if (h_last) begin
        hcount_d = 10'd0;
        vcount_d = v_last ? 10'd0 : vcount_q + 10'd1;
      end else begin
        hcount_d = hcount_q + 10'd1;
      end
    end
  end

  // The output stage samples the pre-advance counters, so colour and sync lag the address by one pixel together.
  always_comb begin
    rgb_d         = rgb_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    vblank_d      = vblank_q;
    frame_start_d = pix_en_q & h_last & v_last;
    if (pix_en_q) begin
      rgb_d    = active ? iReadData : 3'b000;
      hsync_d  = ~((hcount_q >= H_SYNC_LO) && (hcount_q <= H_SYNC_HI));
      vsync_d  = ~((vcount_q >= V_SYNC_LO) && (vcount_q <= V_SYNC_HI));
      vblank_d = ~v_active;
    end
  end

  // NOTE: state flops use non-blocking assignments so all of them update from the same pre-edge values.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      pix_en_q      <= 1'b0;
      hcount_q      <= 10'd0;
      vcount_q      <= 10'd0;
      rgb_q         <= 3'b000;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      vblank_q      <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      pix_en_q      <= pix_en_d;
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      rgb_q         <= rgb_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      vblank_q      <= vblank_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign VGA_RED     = rgb_q[2];
  assign VGA_GREEN   = rgb_q[1];
  assign VGA_BLUE    = rgb_q[0];
  assign VGA_HSYNC   = hsync_q;
  assign VGA_VSYNC   = vsync_q;
  assign oVBlank     = vblank_q;
  assign oFrameStart = frame_start_q;

endmodule
